// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package rf_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for outstanding loads: set on issue, cleared on load writeback,
// with optional masking of a lookup whose load is completing this cycle.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              busy_rs,
    output logic              busy_rt
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Set is applied after clear so a back-to-back load to the same
    // destination keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[clr_addr] = 1'b0;
        if (set_en)
            busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_comb begin
        busy_rs = busy[rs];
        busy_rt = busy[rt];
        if (BYPASS && clr_en && (clr_addr == rs))
            busy_rs = 1'b0;
        if (BYPASS && clr_en && (clr_addr == rt))
            busy_rt = 1'b0;
    end

endmodule

// File: rtl/register_file_sb.sv
// Two-read / two-write register file with write-to-read bypass and a
// per-register busy scoreboard for pending loads.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CNTRL_RS,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] ALU_WB,
    input  logic              CNTRL_MEM,
    input  logic [ADDR_W-1:0] rd_mem,
    input  logic [DATA_W-1:0] MEM_WB,
    input  logic              mark_busy,
    input  logic [ADDR_W-1:0] mark_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] Read_Data,
    output logic [DATA_W-1:0] Read_Data2,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              stall
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic alu_we;
    logic mem_we;

    assign alu_we = CNTRL_RS  && (rd     != '0);
    assign mem_we = CNTRL_MEM && (rd_mem != '0);

    // ALU write is ordered last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (mem_we)
                regs[rd_mem] <= MEM_WB;
            if (alu_we)
                regs[rd] <= ALU_WB;
        end
    end

    always_comb begin
        Read_Data  = (rs == '0) ? '0 : regs[rs];
        Read_Data2 = (rt == '0) ? '0 : regs[rt];
        if (BYPASS) begin
            if (mem_we && (rd_mem == rs))
                Read_Data = MEM_WB;
            if (alu_we && (rd == rs))
                Read_Data = ALU_WB;
            if (mem_we && (rd_mem == rt))
                Read_Data2 = MEM_WB;
            if (alu_we && (rd == rt))
                Read_Data2 = ALU_WB;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (mark_busy),
        .set_addr (mark_rd),
        .clr_en   (CNTRL_MEM),
        .clr_addr (rd_mem),
        .rs       (rs),
        .rt       (rt),
        .busy_rs  (busy_rs),
        .busy_rt  (busy_rt)
    );

    assign stall = busy_rs | busy_rt;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb (BYPASS=1) with an expected-value queue.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        CNTRL_RS;
    logic [4:0]  rd;
    logic [31:0] ALU_WB;
    logic        CNTRL_MEM;
    logic [4:0]  rd_mem;
    logic [31:0] MEM_WB;
    logic        mark_busy;
    logic [4:0]  mark_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] Read_Data;
    logic [31:0] Read_Data2;
    logic        busy_rs;
    logic        busy_rt;
    logic        stall;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    register_file_sb #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .BYPASS   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .CNTRL_RS   (CNTRL_RS),
        .rd         (rd),
        .ALU_WB     (ALU_WB),
        .CNTRL_MEM  (CNTRL_MEM),
        .rd_mem     (rd_mem),
        .MEM_WB     (MEM_WB),
        .mark_busy  (mark_busy),
        .mark_rd    (mark_rd),
        .rs         (rs),
        .rt         (rt),
        .Read_Data  (Read_Data),
        .Read_Data2 (Read_Data2),
        .busy_rs    (busy_rs),
        .busy_rt    (busy_rt),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks run 1 ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL queue_underflow: observed %0h expected <none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic idle();
        CNTRL_RS  = 1'b0;
        CNTRL_MEM = 1'b0;
        mark_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd = '0; ALU_WB = '0; rd_mem = '0; MEM_WB = '0; mark_rd = '0;
        rs = '0; rt = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        rs = 5'd3; rt = 5'd4;
        push("reset_rd1", 32'h0); push("reset_rd2", 32'h0); push("reset_stall", 32'h0);
        settle();
        check(Read_Data); check(Read_Data2); check(stall);

        // write to register 0 is dropped, no bypass either
        CNTRL_RS = 1'b1; rd = 5'd0; ALU_WB = 32'h1; rs = 5'd0;
        push("r0_bypass", 32'h0);
        settle();
        check(Read_Data);
        tick();
        idle();
        push("r0_after", 32'h0);
        settle();
        check(Read_Data);

        // ALU write with same-cycle bypass
        CNTRL_RS = 1'b1; rd = 5'd2; ALU_WB = 32'h2; rs = 5'd2;
        push("alu_bypass", 32'h2);
        settle();
        check(Read_Data);
        tick();
        idle();
        push("alu_stored", 32'h2);
        settle();
        check(Read_Data);

        // MEM write bypass onto read port 2
        CNTRL_MEM = 1'b1; rd_mem = 5'd3; MEM_WB = 32'h33; rt = 5'd3;
        push("mem_bypass_rt", 32'h33);
        settle();
        check(Read_Data2);
        tick();
        idle();

        // same-address collision: ALU wins both the bypass and the store
        CNTRL_RS = 1'b1; rd = 5'd5; ALU_WB = 32'hAAAA;
        CNTRL_MEM = 1'b1; rd_mem = 5'd5; MEM_WB = 32'h5555;
        rs = 5'd5;
        push("collide_bypass", 32'hAAAA);
        settle();
        check(Read_Data);
        tick();
        idle();
        push("collide_stored", 32'hAAAA);
        settle();
        check(Read_Data);

        // two writes to different registers in the same cycle
        CNTRL_RS = 1'b1; rd = 5'd6; ALU_WB = 32'h6666_0006;
        CNTRL_MEM = 1'b1; rd_mem = 5'd8; MEM_WB = 32'h8888_0008;
        tick();
        idle();
        rs = 5'd6; rt = 5'd8;
        push("dual_rs", 32'h6666_0006); push("dual_rt", 32'h8888_0008);
        settle();
        check(Read_Data); check(Read_Data2);

        // mark a load, then complete it
        mark_busy = 1'b1; mark_rd = 5'd7;
        tick();
        idle();
        rs = 5'd7; rt = 5'd7;
        push("busy_rs_set", 32'h1); push("busy_rt_set", 32'h1); push("stall_set", 32'h1);
        settle();
        check(busy_rs); check(busy_rt); check(stall);
        CNTRL_MEM = 1'b1; rd_mem = 5'd7; MEM_WB = 32'h9;
        push("wb_busy_mask", 32'h0); push("wb_data_fwd", 32'h9); push("wb_stall_mask", 32'h0);
        settle();
        check(busy_rs); check(Read_Data); check(stall);
        tick();
        idle();
        push("wb_busy_clr", 32'h0); push("wb_data_stored", 32'h9);
        settle();
        check(busy_rs); check(Read_Data);

        // back-to-back load: set and clear on the same register, set wins
        mark_busy = 1'b1; mark_rd = 5'd7;
        tick();
        CNTRL_MEM = 1'b1; rd_mem = 5'd7; MEM_WB = 32'h77;
        push("b2b_mask", 32'h0);
        settle();
        check(busy_rs);
        tick();
        idle();
        push("b2b_still_busy", 32'h1); push("b2b_data", 32'h77);
        settle();
        check(busy_rs); check(Read_Data);
        CNTRL_MEM = 1'b1; rd_mem = 5'd7; MEM_WB = 32'h78;
        tick();
        idle();
        push("b2b_cleared", 32'h0);
        settle();
        check(busy_rs);

        // ALU writeback leaves the busy bit alone
        mark_busy = 1'b1; mark_rd = 5'd10;
        tick();
        idle();
        CNTRL_RS = 1'b1; rd = 5'd10; ALU_WB = 32'h10;
        tick();
        idle();
        rs = 5'd10; rt = 5'd0;
        push("alu_keeps_busy", 32'h1); push("alu_data_10", 32'h10);
        settle();
        check(busy_rs); check(Read_Data);

        // register 0 can never be marked busy
        mark_busy = 1'b1; mark_rd = 5'd0;
        tick();
        idle();
        rs = 5'd0; rt = 5'd0;
        push("r0_not_busy", 32'h0);
        settle();
        check(busy_rs);

        // fill 1..31 with their index, mark 3 busy, then reset
        for (int i = 1; i < 32; i++) begin
            CNTRL_RS = 1'b1; rd = 5'(i); ALU_WB = 32'(i);
            tick();
        end
        idle();
        mark_busy = 1'b1; mark_rd = 5'd3;
        tick();
        idle();
        rs = 5'd3; rt = 5'd31;
        push("pre_rst_rd1", 32'h3); push("pre_rst_rd2", 32'd31); push("pre_rst_stall", 32'h1);
        settle();
        check(Read_Data); check(Read_Data2); check(stall);

        // reset overrides a write and a mark in the same cycle
        rst = 1'b1;
        CNTRL_RS = 1'b1; rd = 5'd1; ALU_WB = 32'h5;
        mark_busy = 1'b1; mark_rd = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            push("post_rst_rd1", 32'h0); push("post_rst_rd2", 32'h0); push("post_rst_stall", 32'h0);
            settle();
            check(Read_Data); check(Read_Data2); check(stall);
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL queue_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish by 100000ns");
        $fatal(1);
    end

endmodule
